// File: rtl/qif_pkg.sv
// qif_pkg: shared state encoding, datapath width and saturation helper for the QIF neuron blocks.
package qif_pkg;
    typedef enum logic [1:0] {OFF, RUN, DRAIN} qif_state_e;
    localparam int QIF_W = 8;
    localparam logic signed [QIF_W-1:0] QIF_MAX = {1'b0, {(QIF_W-1){1'b1}}};
    localparam logic signed [QIF_W-1:0] QIF_MIN = {1'b1, {(QIF_W-1){1'b0}}};
    // Overflow shows as disagreement between the two top bits of the widened sum.
    function automatic logic signed [QIF_W-1:0] sat_add(input logic signed [QIF_W:0] s);
        return (s[QIF_W] != s[QIF_W-1]) ? (s[QIF_W] ? QIF_MIN : QIF_MAX) : s[QIF_W-1:0];
    endfunction
endpackage

// File: rtl/qif_decay_step.sv
// qif_decay_step: one exponential decay step I - (I >>> SHIFT).
// Small positive values step by one so they still reach zero; negatives settle via -1 >>> s = -1.
module qif_decay_step #(
    parameter int W     = 8,
    parameter int SHIFT = 3
) (
    input  logic signed [W-1:0] cur_i,
    output logic signed [W-1:0] dec_o
);
    logic signed [W-1:0] d_raw, d;
    assign d_raw = cur_i >>> SHIFT;
    assign d     = (d_raw == '0 && cur_i != '0) ? W'(1) : d_raw;
    assign dec_o = cur_i - d;
endmodule

// File: rtl/qif_synapse_driver.sv
// qif_synapse_driver: accumulates weighted spike events into a saturating, periodically decaying
// synaptic current, and drains it to zero on disable before going idle.
module qif_synapse_driver
    import qif_pkg::*;
#(
    parameter int W            = QIF_W,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                spike_valid,
    input  logic signed [W-1:0] spike_weight,
    output logic                spike_ready,
    output logic signed [W-1:0] I_syn,
    output logic                busy
);
    localparam int CW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;
    qif_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] cur_q, cur_d, dec, decayed;
    logic signed [W:0]   sum;
    logic                tick, accept;

    qif_decay_step #(.W(W), .SHIFT(DECAY_SHIFT)) u_decay (.cur_i(cur_q), .dec_o(dec));

    assign tick        = cnt_q == CW'(DECAY_PERIOD - 1);
    assign spike_ready = state_q == RUN;
    assign busy        = state_q != OFF;
    assign accept      = spike_valid && spike_ready;
    assign I_syn       = cur_q;
    // Decay acts on the old current first; the weight is added afterwards at W+1 bits.
    assign decayed     = tick ? dec : cur_q;
    assign sum         = {decayed[W-1], decayed} + (accept ? {spike_weight[W-1], spike_weight} : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cur_d   = '0;
        if (enable) state_d = RUN;
        else if (state_q == RUN) state_d = DRAIN;
        else if (cur_q == '0) state_d = OFF;
        if (state_q != OFF) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            cur_d = sat_add(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
        end
    end
endmodule

// File: tb/tb_qif_synapse_driver.sv
// tb_qif_synapse_driver: directed vectors with hand-computed currents for the synapse driver
// (DECAY_SHIFT = 3, DECAY_PERIOD = 4).
module tb_qif_synapse_driver;
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              spike_valid = 1'b0;
    logic signed [7:0] spike_weight = '0;
    logic              spike_ready;
    logic signed [7:0] I_syn;
    logic              busy;

    typedef struct {
        logic              en;
        logic              v;
        logic signed [7:0] w;
        int                n;
        logic signed [7:0] i;
        logic              rdy;
        logic              bsy;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   failures = 0;
    int   dv[19] = '{22, 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    qif_synapse_driver #(.W(8), .DECAY_SHIFT(3), .DECAY_PERIOD(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_valid(spike_valid),
        .spike_weight(spike_weight), .spike_ready(spike_ready), .I_syn(I_syn), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic outs(input string nm, input int i, input int rdy, input int bsy);
        chk({nm, "_I_syn"}, I_syn, i);
        chk({nm, "_ready"}, spike_ready, rdy);
        chk({nm, "_busy"}, busy, bsy);
    endtask

    task automatic cyc(input logic en, input logic v, input logic signed [7:0] w);
        enable = en;
        spike_valid = v;
        spike_weight = w;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic en, input logic v, input int w, input int n,
                                input int i, input logic rdy = 1'b1, input logic bsy = 1'b1);
        vec_t r;
        r.en = en; r.v = v; r.w = 8'(w); r.n = n; r.i = 8'(i); r.rdy = rdy; r.bsy = bsy;
        vq.push_back(r);
    endfunction

    function automatic void add_hold_tick(input int v);
        add(1, 0, 0, 3, v);
        add(1, 0, 0, 1, v - 1);
    endfunction

    initial begin
        // Enable out of reset; counter starts at 0 in the first RUN cycle.
        add(1, 0, 0, 1, 0);
        // Single event of 40, then decay on every fourth cycle.
        add(1, 1, 40, 1, 40);
        add(1, 0, 0, 2, 40);
        add(1, 0, 0, 1, 35);
        add(1, 0, 0, 3, 35); add(1, 0, 0, 1, 31);
        add(1, 0, 0, 3, 31); add(1, 0, 0, 1, 28);
        add(1, 0, 0, 3, 28); add(1, 0, 0, 1, 25);
        add(1, 0, 0, 3, 25); add(1, 0, 0, 1, 22);
        add(1, 0, 0, 3, 22); add(1, 0, 0, 1, 20);
        // Event on a tick: 40 - 5 + 10.
        add(1, 1, 20, 1, 40);
        add(1, 0, 0, 2, 40);
        add(1, 1, 10, 1, 45);
        // Saturation in both directions (row 4 lands on a tick: 27 - 3 - 100).
        add(1, 1, 100, 1, 127);
        add(1, 1, 100, 1, 127);
        add(1, 1, -100, 1, 27);
        add(1, 1, -100, 1, -76);
        add(1, 1, -100, 1, -128);
        add(1, 1, -100, 1, -128);
        // Preload 5: -128 + 127 = -1, then on the tick -1 decays to 0 and +5 lands.
        add(1, 1, 127, 1, -1);
        add(1, 1, 5, 1, 5);
        for (int v = 5; v >= 1; v--) add_hold_tick(v);
        // Preload -5 and converge upward.
        add(1, 1, -5, 1, -5);
        add(1, 0, 0, 2, -5);
        add(1, 0, 0, 1, -4);
        for (int v = -4; v <= -1; v++) begin
            add(1, 0, 0, 3, v);
            add(1, 0, 0, 1, v + 1);
        end
        // Drop enable together with an event: it is still accepted, then DRAIN refuses events.
        add(1, 1, 20, 1, 20);
        add(0, 1, 5, 1, 25, 0, 1);
        add(0, 1, 50, 1, 25, 0, 1);

        #2 rst_n = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 0, 0, 0);
        rst_n = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            for (int j = 0; j < vq[k].n; j++) begin
                cyc(vq[k].en, vq[k].v, vq[k].w);
                outs($sformatf("row%0d", k), vq[k].i, vq[k].rdy, vq[k].bsy);
            end
        end

        // Drain decays to zero with events still offered and refused.
        for (int k = 0; k < 19; k++) begin
            cyc(0, 1, 50);
            outs($sformatf("drain_tick%0d", k), dv[k], 0, 1);
            if (k != 18) begin
                repeat (3) begin
                    cyc(0, 1, 50);
                    outs($sformatf("drain_hold%0d", k), dv[k], 0, 1);
                end
            end
        end
        cyc(0, 1, 50);
        outs("drain_to_off", 0, 0, 0);
        cyc(0, 1, 50);
        outs("off_hold", 0, 0, 0);

        // Re-enable from DRAIN keeps the current.
        cyc(1, 0, 0);
        outs("reen_run", 0, 1, 1);
        cyc(1, 1, 40);
        outs("reen_load", 40, 1, 1);
        cyc(0, 0, 0);
        outs("reen_drain0", 40, 0, 1);
        cyc(0, 0, 0);
        outs("reen_drain1", 40, 0, 1);
        cyc(0, 0, 0);
        outs("reen_drain_tick", 35, 0, 1);
        cyc(1, 0, 0);
        outs("reen_back_run", 35, 1, 1);
        cyc(1, 1, 5);
        outs("reen_accept", 40, 1, 1);

        // Asynchronous reset mid-DRAIN clears the current without a clock edge.
        cyc(0, 0, 0);
        outs("pre_rst_drain", 40, 0, 1);
        rst_n = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        outs("rst_hold", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qif_synapse_driver.md
Name: qif_synapse_driver

Overview:
- Produces the signed 8-bit synaptic current that drives a QIF neuron's I_syn input.
- Accepts weighted spike events over a valid/ready handshake and accumulates them into a saturating current register.
- Applies periodic exponential decay to the current.
- Drains the current to zero on disable before going idle, so the downstream neuron always sees a clean, settled input.

Parameters:
- W, 8: current and weight width (signed, two's complement).
- DECAY_SHIFT, 3: decay factor; each decay step subtracts I >>> DECAY_SHIFT.
- DECAY_PERIOD, 4: clock cycles between decay steps (>= 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run request; low requests drain-and-stop
- spike_valid  input  1  spike event present
- spike_weight  input  W  signed weight of the event (negative = inhibitory)
- spike_ready  output  1  event accepted this cycle when spike_valid && spike_ready
- I_syn  output  W  signed synaptic current to the neuron, registered
- busy  output  1  high when state != OFF

Behaviour:
- Reset, asynchronous with rst_n low:
  - state = OFF, I_syn = 0, tick counter = 0, spike_ready = 0, busy = 0.
  - Reset mid-operation discards the current immediately; no drain.
- States:
  - OFF -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0.
  - DRAIN -> RUN when enable = 1 (takes priority over the OFF exit).
  - DRAIN -> OFF when enable = 0 and I_syn == 0.
- spike_ready = (state == RUN), decoded from the registered state.
  - An event presented in the cycle RUN exits to DRAIN is still accepted and applied.
  - No events are accepted in OFF or DRAIN.
- Tick counter:
  - Counts 0..DECAY_PERIOD-1 while state != OFF; held at 0 in OFF.
  - tick = (count == DECAY_PERIOD-1), then the counter wraps to 0.
- Current update, one per cycle, registered:
  - d = I >>> DECAY_SHIFT (arithmetic).
  - If d == 0 and I > 0, d = 1. This forces small positive values to reach zero.
  - Negative values converge naturally because -1 >>> s = -1.
  - decayed = tick ? I - d : I.
  - sum = decayed + (accept ? spike_weight : 0), computed at W+1 bits.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - Decay and event in the same cycle: decay is applied to the old I first, then the weight is added, then the result is saturated.
- Latency: an accepted event is visible on I_syn the next cycle.
- OFF: I_syn is held at 0; no updates.
- busy = (state != OFF), registered decode.

Decomposition:
- Shared package qif_pkg holds:
  - The state enum {OFF, RUN, DRAIN}.
  - The width constant QIF_W = 8.
  - Saturation bounds QIF_MAX = 127, QIF_MIN = -128.
  - A sat_add function (W+1-bit sum clamped to W bits).
- One natural sub-module, qif_decay_step: combinational I -> I - d, including the step-by-one rule. Reusable by the neuron's leak path.
- The FSM, tick counter and accumulator register stay in the top module.

Test Plan:
- Reset and enable: hold rst_n = 0, then release with enable = 1.
  - Expect I_syn = 0, busy = 0, spike_ready = 0 during reset.
  - Expect spike_ready = 1 one cycle after OFF -> RUN.
- Single event plus decay: inject w = 40 (DECAY_SHIFT = 3, DECAY_PERIOD = 4).
  - Expect I_syn = 40 on the next cycle.
  - Successive tick values: 35, 31, 28, 25, 22, 20...
  - The value holds for 3 cycles between ticks.
- Saturation:
  - Inject +100 then +100 on consecutive cycles: expect 127, not wrapped.
  - From 0, inject -100, -100: expect -128.
- Small-value and negative convergence:
  - Preload I = 5: ticks give 4, 3, 2, 1, 0.
  - Preload I = -5: ticks give -4, -3, -2, -1, 0.
- Simultaneous event and tick: I = 40, event w = 10 on a tick cycle -> I_syn = 45.
- Drain and re-enable:
  - At I = 20, drop enable together with spike_valid, w = 5: the event is accepted, I = 25, state = DRAIN, spike_ready = 0 next cycle.
  - Decay continues to 0, then OFF with busy = 0.
  - Repeat the drain, raise enable while still in DRAIN: return to RUN without clearing I_syn.
  - Assert rst_n = 0 mid-DRAIN: I_syn = 0 immediately.
